// File: rtl/digilock_ctrl.sv
// Keypad lock controller: collects a NUM_DIGITS code one digit per enter
// pulse, compares it with the stored password, supports password change
// while open, counts failures and enforces a timed lockout.
// Drives the per-digit 5-bit SSD code bus and the status LEDs.
// Optional build macro: DIGILOCK_ECHO_EN -- while entering a code, also show
// the digits already captured to the left of the digit being edited.
module digilock_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_CODE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    enter,
    input  logic                    change,
    input  logic [DIGIT_W-1:0]      switch,
    output logic [5*NUM_DIGITS-1:0] ssd,
    output logic [4:0]              led
);

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int SSD_W  = 5 * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    localparam logic [4:0] SSD_0     = 5'h00;
    localparam logic [4:0] SSD_5     = 5'h05;
    localparam logic [4:0] SSD_C     = 5'h0C;
    localparam logic [4:0] SSD_E     = 5'h0E;
    localparam logic [4:0] SSD_BLANK = 5'h10;
    localparam logic [4:0] SSD_L     = 5'h11;
    localparam logic [4:0] SSD_D     = 5'h12;
    localparam logic [4:0] SSD_P     = 5'h13;
    localparam logic [4:0] SSD_N     = 5'h14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_SET_ENTRY,
        S_LOCKOUT
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   passwd;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [FAIL_W-1:0]   fail_inc;
    logic [TMR_W-1:0]    tmr;
    logic [CODE_W-1:0]   code_cap;

    // Replace digit position p (0 = leftmost) of a code with a new value.
    function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0] code,
                                                    input logic [IDX_W-1:0]  p,
                                                    input logic [DIGIT_W-1:0] d);
        logic [CODE_W-1:0] r;
        r = code;
        r[(NUM_DIGITS - 1 - int'(p)) * DIGIT_W +: DIGIT_W] = d;
        return r;
    endfunction

    // Fail count as shown on the two LED bits, saturated at 3.
    function automatic logic [1:0] sat_fail(input logic [FAIL_W-1:0] n);
        if (int'(n) > 3) return 2'd3;
        return 2'(n);
    endfunction

    // Four-glyph word on the leftmost displays, remaining positions blank.
    function automatic logic [SSD_W-1:0] word4(input logic [4:0] a, input logic [4:0] b,
                                               input logic [4:0] c, input logic [4:0] d);
        logic [SSD_W-1:0] r;
        r = {NUM_DIGITS{SSD_BLANK}};
        r[SSD_W-1 -: 20] = {a, b, c, d};
        return r;
    endfunction

    // Entry view: live switch value at the edit position; captured digits
    // to its left only when echo is built in.
    function automatic logic [SSD_W-1:0] entry_disp(input logic [IDX_W-1:0]   p,
                                                    input logic [DIGIT_W-1:0] sw,
                                                    input logic [CODE_W-1:0]  code);
        logic [SSD_W-1:0] r;
        r = {NUM_DIGITS{SSD_BLANK}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef DIGILOCK_ECHO_EN
            if (i < int'(p))
                r[(NUM_DIGITS - i) * 5 - 1 -: 5] = 5'(code[(NUM_DIGITS - i) * DIGIT_W - 1 -: DIGIT_W]);
`endif
            if (i == int'(p))
                r[(NUM_DIGITS - i) * 5 - 1 -: 5] = 5'(sw);
        end
        return r;
    endfunction

    // Display pattern for the current state.
    function automatic logic [SSD_W-1:0] disp(input state_t                s,
                                              input logic [IDX_W-1:0]   p,
                                              input logic [CODE_W-1:0]  code,
                                              input logic [DIGIT_W-1:0] sw);
        case (s)
            S_IDLE:                disp = word4(SSD_C, SSD_L, SSD_5, SSD_D);
            S_ENTRY, S_SET_ENTRY:  disp = entry_disp(p, sw, code);
            S_OPEN:                disp = word4(SSD_0, SSD_P, SSD_E, SSD_N);
            S_LOCKOUT:             disp = word4(SSD_L, SSD_0, SSD_C, SSD_D);
            default:               disp = {NUM_DIGITS{SSD_BLANK}};
        endcase
    endfunction

    assign fail_inc = fail_cnt + 1'b1;
    assign code_cap = put_digit(code_q, idx, switch);

    // Lock state machine with registered display and LED outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            code_q   <= '0;
            passwd   <= RESET_CODE;
            fail_cnt <= '0;
            tmr      <= '0;
            led      <= '0;
            ssd      <= word4(SSD_C, SSD_L, SSD_5, SSD_D);
        end else begin
            ssd <= disp(state, idx, code_q, switch);
            led <= {sat_fail(fail_cnt), state == S_SET_ENTRY, state == S_LOCKOUT, state == S_OPEN};
            case (state)
                S_IDLE: begin
                    if (!clr && enter) begin
                        state  <= S_ENTRY;
                        idx    <= '0;
                        code_q <= '0;
                    end
                end
                S_ENTRY, S_SET_ENTRY: begin
                    if (clr) begin
                        idx    <= '0;
                        code_q <= '0;
                        if (state == S_SET_ENTRY) state <= S_OPEN;
                    end else if (enter) begin
                        code_q <= code_cap;
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (state == S_ENTRY) begin
                                state <= S_CHECK;
                            end else begin
                                passwd <= code_cap;
                                state  <= S_OPEN;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (code_q == passwd) begin
                        state    <= S_OPEN;
                        fail_cnt <= '0;
                    end else begin
                        fail_cnt <= fail_inc;
                        if (fail_inc == FAIL_W'(MAX_TRIES)) begin
                            state <= S_LOCKOUT;
                            tmr   <= TMR_W'(LOCKOUT_CYCLES);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_OPEN: begin
                    if (!clr) begin
                        if (enter) begin
                            state <= S_IDLE;
                        end else if (change) begin
                            state  <= S_SET_ENTRY;
                            idx    <= '0;
                            code_q <= '0;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (tmr == TMR_W'(1)) begin
                        state    <= S_IDLE;
                        fail_cnt <= '0;
                        tmr      <= '0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digilock_ctrl.sv
// Testbench for digilock_ctrl (default parameters, RESET_CODE = 0x0000).
// Expected outputs are queued as each vector is driven and compared after
// the clock edge that produces them.
module tb_digilock_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        enter = 1'b0;
    logic        change = 1'b0;
    logic [3:0]  switch = 4'h0;
    logic [19:0] ssd;
    logic [4:0]  led;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [19:0] P_IDLE  = {5'h0C, 5'h11, 5'h05, 5'h12};
    localparam logic [19:0] P_OPEN  = {5'h00, 5'h13, 5'h0E, 5'h14};
    localparam logic [19:0] P_LOCK  = {5'h11, 5'h00, 5'h0C, 5'h12};
    localparam logic [19:0] P_BLANK = {4{5'h10}};
    localparam logic [4:0]  L_OPEN  = 5'b00001;
    localparam logic [4:0]  L_SET   = 5'b00100;
    localparam logic [4:0]  L_LOCK  = 5'b11010;

    typedef struct {
        logic        c;
        logic        e;
        logic        ch;
        logic [3:0]  sw;
        bit          chk;
        logic [19:0] ssd;
        logic [4:0]  led;
        string       name;
    } vec_t;

    typedef struct {
        logic [19:0] ssd;
        logic [4:0]  led;
        string       name;
    } exp_t;

    vec_t vq[$];
    exp_t exp_q[$];

    digilock_ctrl #(
        .NUM_DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(16), .RESET_CODE(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .enter(enter), .change(change),
        .switch(switch), .ssd(ssd), .led(led)
    );

    always #5 clk = ~clk;

    // Expected entry display: sw at position idx, captured digits left of it with echo.
    function automatic logic [19:0] ent(input int idx, input logic [3:0] sw, input logic [15:0] cap);
        logic [19:0] r;
        logic [4:0]  slot;
        r = P_BLANK;
        for (int p = 0; p < 4; p++) begin
            slot = 5'h10;
            if (p == idx) slot = {1'b0, sw};
`ifdef DIGILOCK_ECHO_EN
            else if (p < idx) slot = {1'b0, cap[15 - 4*p -: 4]};
`endif
            r[19 - 5*p -: 5] = slot;
        end
        return r;
    endfunction

    function automatic void add(input logic c, input logic e, input logic ch, input logic [3:0] sw,
                                input bit chk, input logic [19:0] s, input logic [4:0] l, input string n);
        vec_t v;
        v.c = c; v.e = e; v.ch = ch; v.sw = sw; v.chk = chk; v.ssd = s; v.led = l; v.name = n;
        vq.push_back(v);
    endfunction

    function automatic void add_digits(input logic [15:0] code);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b0, code[15 - 4*i -: 4], 1'b0, '0, '0, "");
    endfunction

    // Drive one vector for one clock; queue its expectation first.
    task automatic run_one(input vec_t v);
        exp_t x;
        clr = v.c; enter = v.e; change = v.ch; switch = v.sw;
        if (v.chk) begin
            x.ssd = v.ssd; x.led = v.led; x.name = v.name;
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        clr = 1'b0; enter = 1'b0; change = 1'b0;
    endtask

    task automatic test_reset;
        vec_t v;
        exp_t x;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ssd !== P_IDLE || led !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_state: got ssd=%h led=%b, expected ssd=%h led=%b", ssd, led, P_IDLE, 5'b0);
        end
        rst = 1'b0;
        add(0, 1, 0, 4'h0, 1, P_IDLE, 5'b0, "idle_before_entry");
        add(0, 1, 0, 4'h0, 1, ent(0, 4'h0, 16'h0), 5'b0, "entry_pos0");
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add(0, 0, 0, 4'h0, 1, P_BLANK, 5'b0, "check_blank");
        add(0, 0, 0, 4'h0, 1, P_OPEN, L_OPEN, "open_reset_code");
        while (vq.size() != 0) begin
            v = vq.pop_front();
            run_one(v);
            if (v.chk) begin
                x = exp_q.pop_front();
                vectors++;
                if (ssd !== x.ssd || led !== x.led) begin
                    miscompares++;
                    $display("FAIL %s: got ssd=%h led=%b, expected ssd=%h led=%b", x.name, ssd, led, x.ssd, x.led);
                end
            end
        end
    endtask

    task automatic test_change_password;
        vec_t v;
        exp_t x;
        add(0, 0, 1, 4'h0, 1, P_OPEN, L_OPEN, "open_before_change");
        add(0, 1, 0, 4'h1, 1, ent(0, 4'h1, 16'h0), L_SET, "set_mode_pos0");
        add(0, 1, 0, 4'h2, 1, ent(1, 4'h2, 16'h1000), L_SET, "set_mode_pos1");
        add(0, 1, 0, 4'h3, 0, '0, '0, "");
        add(0, 1, 0, 4'h4, 0, '0, '0, "");
        add(0, 0, 0, 4'h0, 1, P_OPEN, L_OPEN, "open_after_set");
        add(0, 1, 0, 4'h0, 1, P_OPEN, L_OPEN, "open_at_relock");
        add(0, 1, 0, 4'h0, 1, P_IDLE, 5'b0, "idle_after_relock");
        add_digits(16'h1234);
        add(0, 0, 0, 4'h0, 1, P_BLANK, 5'b0, "check_new_code");
        add(0, 0, 0, 4'h0, 1, P_OPEN, L_OPEN, "open_new_code");
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add_digits(16'h0000);
        add(0, 0, 0, 4'h0, 1, P_BLANK, 5'b0, "check_old_code");
        add(0, 0, 0, 4'h0, 1, P_IDLE, 5'b01000, "fail_count_1");
        while (vq.size() != 0) begin
            v = vq.pop_front();
            run_one(v);
            if (v.chk) begin
                x = exp_q.pop_front();
                vectors++;
                if (ssd !== x.ssd || led !== x.led) begin
                    miscompares++;
                    $display("FAIL %s: got ssd=%h led=%b, expected ssd=%h led=%b", x.name, ssd, led, x.ssd, x.led);
                end
            end
        end
    endtask

    task automatic test_lockout;
        vec_t v;
        exp_t x;
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add_digits(16'h0000);
        add(0, 0, 0, 4'h0, 1, P_BLANK, 5'b01000, "check_second_fail");
        add(0, 1, 0, 4'h0, 1, P_IDLE, 5'b10000, "fail_count_2");
        add_digits(16'h0000);
        add(0, 0, 0, 4'h0, 1, P_BLANK, 5'b10000, "check_third_fail");
        for (int k = 0; k < 16; k++)
            add(0, 1, 0, 4'h0, 1, P_LOCK, L_LOCK, $sformatf("lockout_cycle_%0d", k));
        add(0, 0, 0, 4'h0, 1, P_IDLE, 5'b0, "idle_after_lockout");
        while (vq.size() != 0) begin
            v = vq.pop_front();
            run_one(v);
            if (v.chk) begin
                x = exp_q.pop_front();
                vectors++;
                if (ssd !== x.ssd || led !== x.led) begin
                    miscompares++;
                    $display("FAIL %s: got ssd=%h led=%b, expected ssd=%h led=%b", x.name, ssd, led, x.ssd, x.led);
                end
            end
        end
    endtask

    task automatic test_clr_entry;
        vec_t v;
        exp_t x;
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add(0, 1, 0, 4'h1, 0, '0, '0, "");
        add(0, 1, 0, 4'h2, 0, '0, '0, "");
        add(1, 1, 0, 4'h9, 1, ent(2, 4'h9, 16'h1200), 5'b0, "entry_before_clr");
        add(0, 1, 0, 4'h1, 1, ent(0, 4'h1, 16'h0), 5'b0, "entry_after_clr");
        add(0, 1, 0, 4'h2, 0, '0, '0, "");
        add(0, 1, 0, 4'h3, 0, '0, '0, "");
        add(0, 1, 0, 4'h4, 0, '0, '0, "");
        add(0, 0, 0, 4'h0, 1, P_BLANK, 5'b0, "check_after_clr");
        add(0, 0, 0, 4'h0, 1, P_OPEN, L_OPEN, "open_after_clr");
        while (vq.size() != 0) begin
            v = vq.pop_front();
            run_one(v);
            if (v.chk) begin
                x = exp_q.pop_front();
                vectors++;
                if (ssd !== x.ssd || led !== x.led) begin
                    miscompares++;
                    $display("FAIL %s: got ssd=%h led=%b, expected ssd=%h led=%b", x.name, ssd, led, x.ssd, x.led);
                end
            end
        end
    endtask

    task automatic test_set_abort;
        vec_t v;
        exp_t x;
        add(0, 0, 1, 4'h0, 1, P_OPEN, L_OPEN, "open_before_set");
        add(0, 1, 0, 4'h5, 0, '0, '0, "");
        add(0, 1, 0, 4'h6, 0, '0, '0, "");
        add(0, 1, 0, 4'h7, 0, '0, '0, "");
        add(1, 0, 0, 4'h8, 1, ent(3, 4'h8, 16'h5670), L_SET, "set_before_abort");
        add(0, 0, 0, 4'h0, 1, P_OPEN, L_OPEN, "open_after_abort");
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add(0, 1, 0, 4'h0, 1, P_IDLE, 5'b0, "idle_before_old_code");
        add_digits(16'h1234);
        add(0, 0, 0, 4'h0, 1, P_BLANK, 5'b0, "check_old_code_kept");
        add(0, 0, 0, 4'h0, 1, P_OPEN, L_OPEN, "old_code_valid");
        while (vq.size() != 0) begin
            v = vq.pop_front();
            run_one(v);
            if (v.chk) begin
                x = exp_q.pop_front();
                vectors++;
                if (ssd !== x.ssd || led !== x.led) begin
                    miscompares++;
                    $display("FAIL %s: got ssd=%h led=%b, expected ssd=%h led=%b", x.name, ssd, led, x.ssd, x.led);
                end
            end
        end
    endtask

    task automatic test_echo;
        vec_t v;
        exp_t x;
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add(0, 1, 0, 4'h7, 0, '0, '0, "");
        add(0, 1, 0, 4'h9, 0, '0, '0, "");
        add(0, 0, 0, 4'h5, 1, ent(2, 4'h5, 16'h7900), 5'b0, "echo_pos2");
        add(1, 0, 0, 4'h0, 1, ent(2, 4'h0, 16'h7900), 5'b0, "echo_before_clr");
        while (vq.size() != 0) begin
            v = vq.pop_front();
            run_one(v);
            if (v.chk) begin
                x = exp_q.pop_front();
                vectors++;
                if (ssd !== x.ssd || led !== x.led) begin
                    miscompares++;
                    $display("FAIL %s: got ssd=%h led=%b, expected ssd=%h led=%b", x.name, ssd, led, x.ssd, x.led);
                end
            end
        end
    endtask

    task automatic test_reset_in_lockout;
        vec_t v;
        exp_t x;
        add_digits(16'h0000);
        add(0, 0, 0, 4'h0, 0, '0, '0, "");
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add_digits(16'h0000);
        add(0, 0, 0, 4'h0, 0, '0, '0, "");
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add_digits(16'h0000);
        add(0, 0, 0, 4'h0, 0, '0, '0, "");
        add(0, 1, 0, 4'h0, 0, '0, '0, "");
        add(0, 0, 0, 4'h0, 1, P_LOCK, L_LOCK, "in_lockout_before_rst");
        while (vq.size() != 0) begin
            v = vq.pop_front();
            run_one(v);
            if (v.chk) begin
                x = exp_q.pop_front();
                vectors++;
                if (ssd !== x.ssd || led !== x.led) begin
                    miscompares++;
                    $display("FAIL %s: got ssd=%h led=%b, expected ssd=%h led=%b", x.name, ssd, led, x.ssd, x.led);
                end
            end
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (ssd !== P_IDLE || led !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset_in_lockout: got ssd=%h led=%b, expected ssd=%h led=%b", ssd, led, P_IDLE, 5'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        add(0, 1, 0, 4'h0, 1, P_IDLE, 5'b0, "idle_after_rst");
        add_digits(16'h0000);
        add(0, 0, 0, 4'h0, 1, P_BLANK, 5'b0, "check_reset_code");
        add(0, 0, 0, 4'h0, 1, P_OPEN, L_OPEN, "reset_code_restored");
        while (vq.size() != 0) begin
            v = vq.pop_front();
            run_one(v);
            if (v.chk) begin
                x = exp_q.pop_front();
                vectors++;
                if (ssd !== x.ssd || led !== x.led) begin
                    miscompares++;
                    $display("FAIL %s: got ssd=%h led=%b, expected ssd=%h led=%b", x.name, ssd, led, x.ssd, x.led);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_change_password;
        test_lockout;
        test_clr_entry;
        test_set_abort;
        test_echo;
        test_reset_in_lockout;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
